// File: rtl/atmega_pio_pkg.sv
// Shared definitions for the ATMEGA-style PIO port with pin-change interrupts.
// Register offsets and constant helper functions used at elaboration.
package atmega_pio_pkg;

   localparam int PORT_OFS   = 'h00;
   localparam int DDR_OFS    = 'h01;
   localparam int PIN_OFS    = 'h02;
   localparam int PCMSK_OFS  = 'h03;
   localparam int PCIFR_OFS  = 'h04;
   localparam int EDGE_R_OFS = 'h05;
   localparam int EDGE_F_OFS = 'h06;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int bus_len_shift(input int w);
      if (w <= 8) return 0;
      else if (w <= 16) return 1;
      else return 2;
   endfunction

endpackage

// File: rtl/pio_in_filter.sv
// One input pin: synchroniser chain, glitch filter counter, filtered level
// and single-cycle rise/fall pulses derived from the filtered level.
module pio_in_filter
   import atmega_pio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic prime_i,
   input  logic io_i,
   output logic pin_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = clog2(FILTER_LEN) + 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   filt_q;
   logic                   prev_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], io_i};
         prev_q <= filt_q;
         // priming loads both copies so no edge is seen when it ends
         if (prime_i) begin
            filt_q <= s;
            prev_q <= s;
            cnt_q  <= '0;
         end else if (tick_i) begin
            if (FILTER_LEN == 1) begin
               filt_q <= s;
            end else if (s == filt_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
               filt_q <= s;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   assign pin_o  = filt_q;
   assign rise_o = filt_q & ~prev_q;
   assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/atmega_pio_pcint.sv
// ATMEGA-style I/O port with filtered inputs, PIN-write toggle and
// edge-selectable pin-change interrupt flags with mask and registered request.
module atmega_pio_pcint
   import atmega_pio_pkg::*;
#(
   parameter PLATFORM = "XILINX",
   parameter int BUS_ADDR_DATA_LEN = 8,
   parameter int PORT_WIDTH = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN = 4,
   parameter int FILTER_DIV = 1,
   parameter int PORT_ADDR = PORT_OFS,
   parameter int DDR_ADDR = DDR_OFS,
   parameter int PIN_ADDR = PIN_OFS,
   parameter int PCMSK_ADDR = PCMSK_OFS,
   parameter int PCIFR_ADDR = PCIFR_OFS,
   parameter int EDGE_R_ADDR = EDGE_R_OFS,
   parameter int EDGE_F_ADDR = EDGE_F_OFS,
   parameter logic [PORT_WIDTH-1:0] PINMASK = '1,
   parameter logic [PORT_WIDTH-1:0] OUT_ENABLED_MASK = '1,
   parameter logic [PORT_WIDTH-1:0] INVERSE_MASK = '0,
   parameter logic [PORT_WIDTH-1:0] PULLUP_MASK = '0,
   parameter logic [PORT_WIDTH-1:0] PULLDN_MASK = '0,
   parameter logic [PORT_WIDTH-1:0] INITIAL_OUTPUT_VALUE = '0,
   parameter logic [PORT_WIDTH-1:0] INITIAL_DIR_VALUE = '0
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
   input  logic                         wr_i,
   input  logic                         rd_i,
   input  logic [PORT_WIDTH-1:0]        bus_i,
   output logic [PORT_WIDTH-1:0]        bus_o,
   input  logic [PORT_WIDTH-1:0]        io_i,
   output logic [PORT_WIDTH-1:0]        io_o,
   output logic [PORT_WIDTH-1:0]        pio_out_io_connect_o,
   input  logic                         int_ack_i,
   output logic                         int_o
);

   localparam int SH = bus_len_shift(PORT_WIDTH);
   localparam int AW = BUS_ADDR_DATA_LEN;
   localparam int DW = clog2(FILTER_DIV) + 1;
   localparam int PW = clog2(SYNC_STAGES + 2) + 1;

   logic [AW-1:0]         word_a;
   logic                  sel_port, sel_ddr, sel_pin;
   logic                  sel_pcmsk, sel_pcifr, sel_er, sel_ef;
   logic [PORT_WIDTH-1:0] port_q, ddr_q, pcmsk_q, pcifr_q;
   logic [PORT_WIDTH-1:0] edge_r_q, edge_f_q;
   logic [PORT_WIDTH-1:0] pin_f, rise, fall, set, clr, oe;
   logic [DW-1:0]         div_q;
   logic [PW-1:0]         prime_q;
   logic                  tick, prime, int_q;

   assign word_a    = addr_i >> SH;
   assign sel_port  = word_a == AW'(PORT_ADDR);
   assign sel_ddr   = word_a == AW'(DDR_ADDR);
   assign sel_pin   = word_a == AW'(PIN_ADDR);
   assign sel_pcmsk = word_a == AW'(PCMSK_ADDR);
   assign sel_pcifr = word_a == AW'(PCIFR_ADDR);
   assign sel_er    = word_a == AW'(EDGE_R_ADDR);
   assign sel_ef    = word_a == AW'(EDGE_F_ADDR);

   assign tick  = div_q == DW'(FILTER_DIV - 1);
   assign prime = prime_q != PW'(SYNC_STAGES + 1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q   <= '0;
         prime_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DW'(1);
         if (prime) prime_q <= prime_q + PW'(1);
      end
   end

   for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_in
      pio_in_filter #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILTER_LEN (FILTER_LEN)
      ) u_flt (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .tick_i (tick),
         .prime_i(prime),
         .io_i   (io_i[g]),
         .pin_o  (pin_f[g]),
         .rise_o (rise[g]),
         .fall_o (fall[g])
      );
   end

   assign set = ((rise & edge_r_q) | (fall & edge_f_q))
              & PINMASK & {PORT_WIDTH{~prime}};
   assign clr = ((wr_i & sel_pcifr) ? bus_i : '0)
              | (int_ack_i ? pcmsk_q : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         port_q   <= INITIAL_OUTPUT_VALUE & PINMASK;
         ddr_q    <= INITIAL_DIR_VALUE & PINMASK;
         pcmsk_q  <= '0;
         pcifr_q  <= '0;
         edge_r_q <= '0;
         edge_f_q <= '0;
         int_q    <= 1'b0;
      end else begin
         if (wr_i) begin
            unique case (1'b1)
               sel_port:  port_q   <= bus_i & PINMASK;
               sel_ddr:   ddr_q    <= bus_i & PINMASK;
               sel_pin:   port_q   <= (port_q ^ bus_i) & PINMASK;
               sel_pcmsk: pcmsk_q  <= bus_i & PINMASK;
               sel_er:    edge_r_q <= bus_i & PINMASK;
               sel_ef:    edge_f_q <= bus_i & PINMASK;
               default: ;
            endcase
         end
         // a new edge wins over a same-cycle clear
         pcifr_q <= ((pcifr_q & ~clr) | set) & PINMASK;
         int_q   <= |(pcifr_q & pcmsk_q);
      end
   end

   assign int_o = int_q;

   always_comb begin
      bus_o = '0;
      if (rd_i & ~rst_i) begin
         unique case (1'b1)
            sel_port:  bus_o = port_q;
            sel_ddr:   bus_o = ddr_q;
            sel_pin:   bus_o = (pin_f ^ INVERSE_MASK) & PINMASK;
            sel_pcmsk: bus_o = pcmsk_q;
            sel_pcifr: bus_o = pcifr_q;
            sel_er:    bus_o = edge_r_q;
            sel_ef:    bus_o = edge_f_q;
            default:   bus_o = '0;
         endcase
      end
   end

   assign oe = ddr_q & PINMASK & OUT_ENABLED_MASK;
   assign pio_out_io_connect_o = oe;

   for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_out
      assign io_o[g] = oe[g] ? (port_q[g] ^ INVERSE_MASK[g]) : 1'bz;
      if (PLATFORM == "XILINX" && PULLUP_MASK[g]) begin : g_pu
         pullup pu (io_o[g]);
      end
      if (PLATFORM == "XILINX" && PULLDN_MASK[g]) begin : g_pd
         pulldown pd (io_o[g]);
      end
   end

endmodule

// File: doc/atmega_pio_pcint.md
Name: atmega_pio_pcint

Overview:
Parametrised successor to the team's ATMEGA-style PIO port. Adds:
- a configurable input synchroniser and per-pin glitch filter;
- AVR-style PIN-write toggle of PORT;
- per-pin edge-select pin-change interrupts with a mask register, write-1-to-clear flags and a registered interrupt request.

It sits on the 8-bit-address I/O bus beside the CPU core, one instance per port. int_o goes to the interrupt controller.

Parameters:
PLATFORM, "XILINX", selects pull primitives (XILINX only; others: none).
BUS_ADDR_DATA_LEN, 8, I/O address width.
PORT_WIDTH, 8, pins per port (1..32).
SYNC_STAGES, 2, input synchroniser flops (>=2).
FILTER_LEN, 4, consecutive agreeing samples to accept a level; 1 = filter bypassed.
FILTER_DIV, 1, filter sample every FILTER_DIV clocks (shared prescaler).
PORT_ADDR / DDR_ADDR / PIN_ADDR, 'h00/'h01/'h02, data, direction and pin registers.
PCMSK_ADDR / PCIFR_ADDR / EDGE_R_ADDR / EDGE_F_ADDR, 'h03/'h04/'h05/'h06, mask, flags, rise-enable and fall-enable registers.
PINMASK, all-ones, implemented pins; unimplemented bits read 0, ignore writes, never flag.
OUT_ENABLED_MASK, all-ones, pins allowed to drive.
INVERSE_MASK, 'h0, invert pin in and out.
PULLUP_MASK / PULLDN_MASK, 'h0, pull primitives per pin.
INITIAL_OUTPUT_VALUE / INITIAL_DIR_VALUE, 'h0, PORT/DDR reset values.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
addr_i  in  BUS_ADDR_DATA_LEN  register address (decoded on bits [MSB:BUS_LEN_SHIFT], BUS_LEN_SHIFT = 0/1/2 for width <=8/<=16/>16).
wr_i  in  1  write strobe.
rd_i  in  1  read strobe.
bus_i  in  PORT_WIDTH  write data.
bus_o  out  PORT_WIDTH  read data, combinational.
io_i  in  PORT_WIDTH  raw pad inputs.
io_o  out  PORT_WIDTH  pad outputs, Z when not driven.
pio_out_io_connect_o  out  PORT_WIDTH  per-pin output-enable (DDR & PINMASK & OUT_ENABLED_MASK).
int_ack_i  in  1  one-cycle interrupt acknowledge from controller.
int_o  out  1  registered interrupt request.

Behaviour:
Reset (rst_i=1 at clock edge):
- PORT=INITIAL_OUTPUT_VALUE, DDR=INITIAL_DIR_VALUE.
- PCMSK, PCIFR, EDGE_R, EDGE_F, sync chain, filter counters, filtered PIN all 0.
- int_o=0; bus_o=0 while rst_i.
- Reset mid-operation aborts everything; pending flags are lost.

Writes (wr_i, effective next edge):
- PORT/DDR/PCMSK/EDGE_R/EDGE_F: load bus_i.
- PIN: PORT ^= bus_i (toggle).
- PCIFR: write-1-to-clear.

Reads (rd_i & ~rst_i):
- bus_o same cycle: PORT, DDR, PIN (filtered, ^INVERSE_MASK), PCMSK, PCIFR, EDGE_R, EDGE_F.
- Unmapped address or no rd_i: 0.

Input path:
- io_i passes through SYNC_STAGES flops, giving s.
- Per pin, a counter of width clog2(FILTER_LEN)+1, clocked on prescaler tick:
  - s == filtered: counter cleared;
  - else counter increments; on reaching FILTER_LEN-1, filtered <= s and counter cleared.
- FILTER_LEN=1: filtered <= s every tick.
- Input latency is SYNC_STAGES + FILTER_LEN*FILTER_DIV clocks, ±FILTER_DIV.

Priming:
- For SYNC_STAGES+1 clocks after reset release, filtered <= s directly with no flag generation (startup counter).
- This prevents spurious edges out of reset.

Edge flags:
- A filtered 0->1 with EDGE_R[i], or 1->0 with EDGE_F[i], sets PCIFR[i] the clock after the filtered change.
- Flags set regardless of PCMSK.

Interrupt:
- int_o <= |(PCIFR & PCMSK), one clock later.
- int_ack_i clears PCIFR bits where PCMSK=1.

Simultaneous events:
- Set beats clear (W1C or ack) in the same cycle.
- Write to EDGE_* applies from the next cycle's detection.
- PIN toggle write and PORT write in one cycle cannot occur (single address).

Output path:
- io_o[i] = (DDR[i] & enabled) ? PORT[i]^INVERSE_MASK[i] : Z.
- Pull primitives as PLATFORM allows.

Decomposition:
- Package atmega_pio_pkg: register offset defaults, BUS_LEN_SHIFT function, clog2 function.
- Sub-module pio_in_filter (one pin: sync chain, counter, filtered bit, edge pulses rise/fall), instantiated PORT_WIDTH times in a generate loop.
- Prescaler and startup counter stay in the top module.

Test Plan:
1. Reset with INITIAL_DIR_VALUE='h0F, INITIAL_OUTPUT_VALUE='h05 -> DDR reads 'h0F, PORT 'h05, io_o[3:0]=0101, io_o[7:4]=Z, int_o=0, no PCIFR bits after priming.
2. Write PORT='hAA, then PIN='h0F -> PORT reads 'hA5; bits without DDR stay Z.
3. FILTER_LEN=4, FILTER_DIV=1, SYNC_STAGES=2: 2-clock high glitch on io_i[0] -> PIN[0] stays 0, PCIFR 0. Held high 10 clocks -> PIN[0]=1 exactly 6 clocks after the io_i change.
4. EDGE_R='h01, EDGE_F=0, PCMSK='h01: rise on pin 0 -> PCIFR='h01, int_o=1 next clock. Fall produces no flag. Write PCIFR='h01 -> int_o=0 the clock after the write.
5. Flag pending with PCMSK=0 -> int_o=0. Set PCMSK='h01 -> int_o=1. int_ack_i on the same cycle as a new rise on pin 0 -> flag remains 1.
6. Assert rst_i mid-filter-count with flags set -> all registers at reset values, no flag generated during the priming window afterwards.
